// File: rtl/microwave_timer_pkg.sv
// Shared types and constants for the microwave M:SS countdown controller.
package microwave_timer_pkg;

  localparam int unsigned BcdW = 4;

  localparam logic [BcdW-1:0] SEC_ONES_MAX = 4'd9;
  localparam logic [BcdW-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [BcdW-1:0] MIN_MAX      = 4'd9;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRunning = 3'd1,
    StPaused  = 3'd2,
    StDone    = 3'd3
  } state_e;

  // Saturate an incoming BCD value to the digit's maximum.
  function automatic logic [BcdW-1:0] bcd_clamp(logic [BcdW-1:0] d, logic [BcdW-1:0] max);
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/microwave_timer_ctrl_bcd_down_digit.sv
// One BCD down-counting digit with clear/load/enable; wraps 0 -> MAX and flags terminal count.
module bcd_down_digit
  import microwave_timer_pkg::*;
#(
  parameter logic [BcdW-1:0] MAX = 4'd9
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            load,
  input  logic [BcdW-1:0] data,
  input  logic            en,
  output logic [BcdW-1:0] digit,
  output logic            zero,
  output logic            tc
);

  logic [BcdW-1:0] digit_q, digit_d;

  // Next digit value: clear beats load beats decrement.
  always_comb begin
    digit_d = digit_q;
    if (clear) begin
      digit_d = '0;
    end else if (load) begin
      digit_d = bcd_clamp(data, MAX);
    end else if (en) begin
      digit_d = (digit_q == '0) ? MAX : digit_q - 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign zero  = (digit_q == '0);
  // Borrow into the next more significant digit.
  assign tc    = en && zero;

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave countdown controller: M:SS BCD timer, start/pause/clear/done FSM, door interlock.
// Optional build macro DONE_HOLD_EN: done is held for DONE_TICKS tick pulses before returning
// to IDLE; without it, done is a single-cycle pulse.
module microwave_timer_ctrl
  import microwave_timer_pkg::*;
#(
  parameter int unsigned DONE_TICKS = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            tick,
  input  logic            load,
  input  logic [BcdW-1:0] data_min,
  input  logic [BcdW-1:0] data_sec_tens,
  input  logic [BcdW-1:0] data_sec_ones,
  input  logic            start,
  input  logic            stop_clear,
  input  logic            door_closed,
  output logic [BcdW-1:0] min_digit,
  output logic [BcdW-1:0] sec_tens_digit,
  output logic [BcdW-1:0] sec_ones_digit,
  output logic            mag_on,
  output logic            done,
  output logic [2:0]      state
);

  state_e state_q, state_d;
  logic   mag_on_q, done_q;

  logic clr_digits, ld_digits, dec_en;
  logic ones_tc, tens_tc, min_tc_unused;
  logic ones_zero, tens_zero, min_zero;
  logic time_zero, time_one;

`ifdef DONE_HOLD_EN
  localparam logic [3:0] HoldLast = 4'(DONE_TICKS - 1);
  logic [3:0] hold_q, hold_d;
`else
  logic [3:0] unused_done_ticks;
  assign unused_done_ticks = 4'(DONE_TICKS);
`endif

  assign time_zero = min_zero && tens_zero && ones_zero;
  // The next decrement from 0:01 lands on 0:00.
  assign time_one  = min_zero && tens_zero && (sec_ones_digit == 4'd1);

  // Next-state and digit control; priority door open > stop_clear > start > load > tick.
  always_comb begin
    state_d    = state_q;
    clr_digits = 1'b0;
    ld_digits  = 1'b0;
    dec_en     = 1'b0;
`ifdef DONE_HOLD_EN
    hold_d     = hold_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (stop_clear) begin
          clr_digits = 1'b1;
        end else if (start && door_closed && !time_zero) begin
          state_d = StRunning;
        end else if (load) begin
          ld_digits = 1'b1;
        end
      end
      StRunning: begin
        if (!door_closed || stop_clear) begin
          state_d = StPaused;
        end else if (tick) begin
          dec_en = 1'b1;
          if (time_one) begin
            state_d = StDone;
`ifdef DONE_HOLD_EN
            hold_d  = '0;
`endif
          end
        end
      end
      StPaused: begin
        if (stop_clear) begin
          state_d    = StIdle;
          clr_digits = 1'b1;
        end else if (start && door_closed) begin
          state_d = StRunning;
        end
      end
      StDone: begin
        if (stop_clear) begin
          state_d    = StIdle;
          clr_digits = 1'b1;
        end else if (load) begin
          state_d   = StIdle;
          ld_digits = 1'b1;
        end else begin
`ifdef DONE_HOLD_EN
          if (tick) begin
            if (hold_q == HoldLast) begin
              state_d = StIdle;
            end else begin
              hold_d = hold_q + 4'd1;
            end
          end
`else
          state_d = StIdle;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and registered status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      mag_on_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef DONE_HOLD_EN
      hold_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      mag_on_q <= (state_d == StRunning);
      done_q   <= (state_d == StDone);
`ifdef DONE_HOLD_EN
      hold_q   <= hold_d;
`endif
    end
  end

  bcd_down_digit #(
    .MAX(SEC_ONES_MAX)
  ) u_sec_ones (
    .clock(clock),
    .reset(reset),
    .clear(clr_digits),
    .load (ld_digits),
    .data (data_sec_ones),
    .en   (dec_en),
    .digit(sec_ones_digit),
    .zero (ones_zero),
    .tc   (ones_tc)
  );

  bcd_down_digit #(
    .MAX(SEC_TENS_MAX)
  ) u_sec_tens (
    .clock(clock),
    .reset(reset),
    .clear(clr_digits),
    .load (ld_digits),
    .data (data_sec_tens),
    .en   (ones_tc),
    .digit(sec_tens_digit),
    .zero (tens_zero),
    .tc   (tens_tc)
  );

  bcd_down_digit #(
    .MAX(MIN_MAX)
  ) u_min (
    .clock(clock),
    .reset(reset),
    .clear(clr_digits),
    .load (ld_digits),
    .data (data_min),
    .en   (tens_tc),
    .digit(min_digit),
    .zero (min_zero),
    .tc   (min_tc_unused)
  );

  assign state  = state_q;
  assign mag_on = mag_on_q;
  assign done   = done_q;

endmodule

// File: doc/microwave_timer_ctrl.md
Name: microwave_timer_ctrl

Overview:
Controller sequencing the microwave countdown timer, formatted M:SS (minute ones mod-10, seconds tens mod-6, seconds ones mod-10).
- Owns the three BCD down-counting digits and their load/clear/enable chaining.
- Runs the start/pause/clear/done FSM with door interlock.
- Drives the magnetron enable and display digits.
- Advances only on an external 1 Hz tick enable.

Parameters:
DONE_TICKS, 3, number of tick periods done stays high when DONE_HOLD_EN is defined (1..15)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
tick  input  1  one-cycle pulse, 1 per second
load  input  1  one-cycle pulse: capture data_* into digits
data_min  input  4  minute ones BCD
data_sec_tens  input  4  seconds tens BCD
data_sec_ones  input  4  seconds ones BCD
start  input  1  one-cycle pulse: begin/resume cooking
stop_clear  input  1  one-cycle pulse: pause when running; clear otherwise
door_closed  input  1  level, 1 = door shut
min_digit  output  4  minute ones digit
sec_tens_digit  output  4  seconds tens digit
sec_ones_digit  output  4  seconds ones digit
mag_on  output  1  magnetron enable
done  output  1  cooking finished indicator
state  output  3  FSM state code

Behaviour:
- Reset state: state=IDLE, all digits 0, mag_on=0, done=0. Reset mid-run aborts immediately; no residual time.
- FSM states: IDLE=0, RUNNING=1, PAUSED=2, DONE=3.
- All outputs are registered. mag_on=1 exactly when state==RUNNING.
- Load:
  - Accepted only in IDLE and DONE; DONE→IDLE on load.
  - Ignored in RUNNING and PAUSED.
  - Clamping: data_min>9 → 9; data_sec_tens>5 → 5; data_sec_ones>9 → 9.
  - Digits update on the cycle after the load pulse.
- IDLE→RUNNING: start=1, door_closed=1, and time≠0:00.
  - start with time 0:00 or door open is ignored.
- RUNNING, on tick: decrement M:SS by one second, with borrow chain:
  - sec_ones 0→9 borrows from sec_tens.
  - sec_tens 0→5 borrows from min.
  - Minute ones never borrows below 0.
- Decrement that reaches 0:00 → DONE on the same edge (digits show 0:00, mag_on falls).
- RUNNING→PAUSED: stop_clear=1 or door_closed=0. Digits are frozen.
- PAUSED→RUNNING: start=1 and door_closed=1.
- PAUSED→IDLE: stop_clear=1; all digits cleared to 0.
- IDLE: stop_clear clears digits.
- DONE: done=1. start ignored. stop_clear or load → IDLE; stop_clear also clears done.
- Priority within one cycle: reset > door open > stop_clear > start > load > tick.
  - tick coinciding with pause (door open or stop_clear) does not decrement.
  - tick coinciding with the start that enters RUNNING does not decrement; first decrement is on the next tick.
- The tick input does not need to be periodic; each pulse decrements at most one second.

Optional Feature:
Macro DONE_HOLD_EN.
- Defined: on entering DONE, done rises and stays high for DONE_TICKS tick pulses, then the FSM returns to IDLE automatically. stop_clear or load exits earlier.
- Undefined: done is a single-cycle pulse. DONE→IDLE on the next clock edge; DONE_TICKS is unused.

Decomposition:
- Package microwave_timer_pkg: state codes (IDLE/RUNNING/PAUSED/DONE), digit max constants (SEC_ONES_MAX=9, SEC_TENS_MAX=5, MIN_MAX=9), BCD width=4.
- One sub-module, bcd_down_digit, instantiated three times:
  - Parameter MAX.
  - Ports: clock, reset, clear, load, data, en → digit, zero, tc.
  - tc = en && digit==0; the borrow chain links tc to the next digit's en.
- The FSM, priority logic and done-hold counter stay in microwave_timer_ctrl.

Test Plan:
- Reset, load 1:05, door closed, start, 65 ticks → digits step 1:04…1:00, 0:59…0:01, 0:00; mag_on high 65 tick periods; done asserts on the 65th tick; state=DONE.
- Load 0:30, start, 5 ticks, door_closed=0 → state=PAUSED, digits 0:25, mag_on=0. Further ticks give no change. Door closed + start → RUNNING.
- Running at 0:10, stop_clear → PAUSED at 0:10; second stop_clear → IDLE, digits 0:00. start now ignored (stays IDLE).
- Load data_min=12, sec_tens=7, sec_ones=15 → digits 9:59. Load during RUNNING → ignored.
- start and tick in the same cycle from IDLE at 0:02 → no decrement that cycle; next tick → 0:01. stop_clear + start together while RUNNING → PAUSED.
- With DONE_HOLD_EN, DONE_TICKS=3: done high for exactly 3 ticks, then IDLE. Without the macro: done is high for one cycle only.
